// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 5-stage pipeline hazard, flush, forwarding and memory-wait controller
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             rs1_used_id,
    input  logic             rs2_used_id,
    input  logic [4:0]       rd_ex,
    input  logic             memread_ex,
    input  logic [1:0]       jump_flag_ex,
    input  logic [4:0]       rs1_ex,
    input  logic [4:0]       rs2_ex,
    input  logic [4:0]       rd_mem,
    input  logic             regwrite_mem,
    input  logic [4:0]       rd_wb,
    input  logic             regwrite_wb,
    input  logic             mem_req_mem,
    input  logic             mem_ready,
    output logic             pc_write_en,
    output logic             ifid_write_en,
    output logic             idex_write_en,
    output logic             exmem_write_en,
    output logic             memwb_write_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;
    localparam logic [7:0] WAIT_LAST   = 8'(MEM_TIMEOUT - 1);

    logic [0:0] state;
    logic [7:0] wait_cnt;
    logic       mem_err_q;

    logic in_wait;
    logic wait_exit;
    logic timeout;
    logic freeze;
    logic jump;
    logic load_use;
    logic jump_flush;

    assign in_wait   = (state == ST_MEM_WAIT);
    assign timeout   = in_wait && !mem_ready && (wait_cnt == WAIT_LAST);
    assign wait_exit = in_wait && (mem_ready || (wait_cnt == WAIT_LAST));
    // The exit cycle of a wait is treated as RUN so the access retires without re-freezing.
    assign freeze    = (in_wait && !wait_exit) || (!in_wait && mem_req_mem && !mem_ready);
    assign jump      = (jump_flag_ex != 2'b00);
    assign load_use  = memread_ex && (rd_ex != 5'd0) &&
                       ((rs1_used_id && (rs1_id == rd_ex)) || (rs2_used_id && (rs2_id == rd_ex)));
    assign jump_flush = reset && !freeze && jump;
    assign mem_err    = mem_err_q;

    always_comb begin
        pc_write_en    = 1'b1;
        ifid_write_en  = 1'b1;
        idex_write_en  = 1'b1;
        exmem_write_en = 1'b1;
        memwb_write_en = 1'b1;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        stall          = 1'b0;
        if (!reset) begin
            pc_write_en    = 1'b0;
            ifid_write_en  = 1'b0;
            idex_write_en  = 1'b0;
            exmem_write_en = 1'b0;
            memwb_write_en = 1'b0;
            ifid_flush     = 1'b1;
            idex_flush     = 1'b1;
            stall          = 1'b1;
        end else if (freeze) begin
            pc_write_en    = 1'b0;
            ifid_write_en  = 1'b0;
            idex_write_en  = 1'b0;
            exmem_write_en = 1'b0;
            memwb_write_en = 1'b0;
            stall          = 1'b1;
        end else if (jump) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_flush    = 1'b1;
            stall         = 1'b1;
        end
    end

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (reset) begin
            if (regwrite_mem && (rd_mem != 5'd0) && (rd_mem == rs1_ex)) begin
                fwd_a = 2'b10;
            end else if (regwrite_wb && (rd_wb != 5'd0) && (rd_wb == rs1_ex)) begin
                fwd_a = 2'b01;
            end
            if (regwrite_mem && (rd_mem != 5'd0) && (rd_mem == rs2_ex)) begin
                fwd_b = 2'b10;
            end else if (regwrite_wb && (rd_wb != 5'd0) && (rd_wb == rs2_ex)) begin
                fwd_b = 2'b01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_RUN;
            wait_cnt  <= 8'd0;
            mem_err_q <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    wait_cnt <= 8'd0;
                    if (mem_req_mem && !mem_ready) begin
                        state <= ST_MEM_WAIT;
                    end
                end
                ST_MEM_WAIT: begin
                    if (wait_exit) begin
                        state    <= ST_RUN;
                        wait_cnt <= 8'd0;
                        if (timeout) begin
                            mem_err_q <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state    <= ST_RUN;
                    wait_cnt <= 8'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Counters saturate at all-ones.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
            if (jump_flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    logic unused_perf;
    assign unused_perf = jump_flush;
    assign stall_cnt   = '0;
    assign flush_cnt   = '0;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage Risc5CPU pipeline (IF/ID/EX/MEM/WB).
- Detects load-use hazards and inserts one bubble.
- Squashes wrong-path instructions on taken jumps and branches.
- Generates EX-stage forwarding selects.
- Freezes the whole pipeline while data memory is not ready, with a timeout FSM.
- Drives the pipeline-register enables and flushes, and the top-level Stall signal.

Parameters:
- MEM_TIMEOUT, 16: maximum MEM_WAIT cycles before forced release; legal range 2..255.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- rs1_id, rs2_id  in  5 each  source registers of the instruction in ID
- rs1_used_id, rs2_used_id  in  1 each  the ID instruction actually reads rs1/rs2
- rd_ex  in  5  destination register in EX
- memread_ex  in  1  EX instruction is a load
- jump_flag_ex  in  2  00 none, 01 jal, 10 jalr, 11 branch taken
- rs1_ex, rs2_ex  in  5 each  source registers of the instruction in EX
- rd_mem, regwrite_mem  in  5, 1  MEM-stage writeback info
- rd_wb, regwrite_wb  in  5, 1  WB-stage writeback info
- mem_req_mem  in  1  MEM stage is issuing a data-memory access
- mem_ready  in  1  data memory completes the access this cycle
- pc_write_en  out  1  PC register enable
- ifid_write_en, idex_write_en, exmem_write_en, memwb_write_en  out  1 each  pipeline-register enables
- ifid_flush, idex_flush  out  1 each  load a NOP into the register
- fwd_a, fwd_b  out  2 each  ALU_A/ALU_B source select: 00 regfile, 01 WB, 10 MEM
- stall  out  1  any freeze or bubble is active this cycle
- mem_err  out  1  sticky flag: a memory timeout has occurred
- stall_cnt, flush_cnt  out  CNT_W each  performance counters

Behaviour:
- Reset (reset=0 sampled at a clock edge):
  - State returns to RUN; wait counter, mem_err and both performance counters clear to 0.
  - While reset=0, outputs are forced: all write enables 0, ifid_flush=idex_flush=1, fwd_a=fwd_b=00, stall=1.
  - Reset mid-MEM_WAIT aborts the wait immediately, with no mem_err.
- States:
  - RUN: MEM_WAIT is entered when mem_req_mem=1 and mem_ready=0. Otherwise remain in RUN.
  - MEM_WAIT: the wait counter increments each cycle. Exit to RUN on mem_ready=1. When the counter reaches MEM_TIMEOUT-1 with no ready, exit to RUN and set mem_err=1.
- MEM_WAIT outputs:
  - All five enables are 0, no flushes, stall=1.
  - The exit cycle (mem_ready=1 or timeout) already behaves as RUN, so the access retires that cycle.
  - The request is not re-issued after a timeout.
- RUN priority, evaluated combinationally from current inputs:
  1. mem_req_mem & !mem_ready: freeze as in MEM_WAIT, same cycle.
  2. jump_flag_ex != 00: ifid_flush=1, idex_flush=1, all enables 1. A load-use hazard in ID is ignored because that instruction is squashed.
  3. Load-use hazard: memread_ex & rd_ex!=0 & ((rs1_used_id & rs1_id==rd_ex) | (rs2_used_id & rs2_id==rd_ex)). Response: pc_write_en=0, ifid_write_en=0, idex_flush=1, stall=1, other enables 1. Exactly one bubble per hazard, because the load advances to MEM.
  4. Otherwise all enables 1, no flush, stall=0.
- Forwarding (independent of state):
  - fwd_a=10 if regwrite_mem & rd_mem!=0 & rd_mem==rs1_ex.
  - Else fwd_a=01 if regwrite_wb & rd_wb!=0 & rd_wb==rs1_ex.
  - Else fwd_a=00.
  - fwd_b is identical using rs2_ex. MEM has priority over WB; x0 is never forwarded.
- mem_err: stays 1 until reset.
- Counters: saturate at all-ones, do not wrap.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on every cycle with stall=1 and reset=1.
  - flush_cnt increments on every cycle with ifid_flush=1 caused by a jump (not by reset).
- Undefined: both ports are driven constant 0 and no counter flops are synthesized. All other behaviour is unchanged.

Test Plan:
- Reset: hold reset=0 for 2 cycles with random inputs -> pc_write_en=0, idex_flush=1, stall=1, mem_err=0. Release -> pc_write_en=1 and stall=0 next cycle with idle inputs.
- Load-use: memread_ex=1, rd_ex=5, rs1_id=5, rs1_used_id=1 -> exactly one cycle with pc_write_en=0, ifid_write_en=0, idex_flush=1. Same with rd_ex=0 -> no stall.
- Jump beats load-use: jump_flag_ex=11 together with the load-use condition above -> ifid_flush=idex_flush=1, pc_write_en=1, stall=0. With the macro defined, flush_cnt goes 0->1.
- Forwarding: regwrite_mem=1, rd_mem=3, regwrite_wb=1, rd_wb=3, rs1_ex=3, rs2_ex=3 -> fwd_a=fwd_b=10. Clear regwrite_mem -> 01. rd_mem=rd_wb=0 -> 00.
- Memory wait: mem_req_mem=1, mem_ready low for 4 cycles then high -> exactly 4 frozen cycles (all enables 0), release on the ready cycle, mem_err=0. With the macro defined, stall_cnt=4.
- Timeout: MEM_TIMEOUT=16, mem_ready held 0 -> freeze lasts 16 cycles, then RUN and mem_err=1. mem_err stays 1 until reset=0 is applied.
